// File: rtl/irq_defs.sv
// Shared interrupt definitions: source count, register map and the
// per-line event rule used by the source conditioner.
package irq_defs;

  localparam int NUM_IRQ = 16;

  typedef enum logic [1:0] {
    REG_ENABLE    = 2'd0,
    REG_EDGE_MODE = 2'd1,
    REG_STATUS    = 2'd2,
    REG_SYNC_RAW  = 2'd3
  } reg_addr_e;

  typedef logic [NUM_IRQ-1:0] irq_vec_t;

  function automatic irq_vec_t irq_event(
    input irq_vec_t sync,
    input irq_vec_t prev,
    input irq_vec_t edge_mode
  );
    return (edge_mode & sync & ~prev) | (~edge_mode & sync);
  endfunction

endpackage

// File: rtl/irq_sync.sv
// Multi-flop synchronizer bank for asynchronous request lines,
// cleared by the synchronous reset.
module irq_sync #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++)
        stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/irq_source_conditioner.sv
// Synchronizes raw interrupt sources, applies edge/level and enable
// conditioning, and keeps sticky W1C status behind a small reg port.
module irq_source_conditioner
  import irq_defs::*;
#(
  parameter int       SYNC_STAGES  = 2,
  parameter irq_vec_t RESET_ENABLE = 16'h0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] raw_lines,
  input  logic               reg_we,
  input  logic               reg_re,
  input  logic [1:0]         reg_addr,
  input  logic [NUM_IRQ-1:0] reg_wdata,
  output logic [NUM_IRQ-1:0] reg_rdata,
  output logic [NUM_IRQ-1:0] interrupt_lines
);

  irq_vec_t sync;
  irq_vec_t ev;
  irq_vec_t clr;
  irq_vec_t prev_q;
  irq_vec_t en_q, en_d;
  irq_vec_t edge_q, edge_d;
  irq_vec_t status_q, status_d;
  irq_vec_t irq_q, irq_d;
  irq_vec_t rdata_q, rdata_d;

  logic wr_en, wr_edge, wr_stat;

  irq_sync #(
    .WIDTH(NUM_IRQ),
    .DEPTH(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d_i  (raw_lines),
    .q_o  (sync)
  );

  assign wr_en   = reg_we && (reg_addr == REG_ENABLE);
  assign wr_edge = reg_we && (reg_addr == REG_EDGE_MODE);
  assign wr_stat = reg_we && (reg_addr == REG_STATUS);

  always_comb begin
    en_d    = en_q;
    edge_d  = edge_q;
    clr     = '0;
    rdata_d = rdata_q;
    ev      = irq_event(sync, prev_q, edge_q);

    unique case (1'b1)
      wr_en:   en_d   = reg_wdata;
      wr_edge: edge_d = reg_wdata;
      wr_stat: clr    = reg_wdata;
      default: ;
    endcase

    // A set in the same cycle as a W1C clear must survive.
    status_d = (status_q & ~clr) | ev;
    irq_d    = en_q & ev;

    if (reg_re) begin
      unique case (reg_addr_e'(reg_addr))
        REG_ENABLE:    rdata_d = en_q;
        REG_EDGE_MODE: rdata_d = edge_q;
        REG_STATUS:    rdata_d = status_q;
        REG_SYNC_RAW:  rdata_d = sync;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q   <= '0;
      en_q     <= RESET_ENABLE;
      edge_q   <= '0;
      status_q <= '0;
      irq_q    <= '0;
      rdata_q  <= '0;
    end else begin
      prev_q   <= sync;
      en_q     <= en_d;
      edge_q   <= edge_d;
      status_q <= status_d;
      irq_q    <= irq_d;
      rdata_q  <= rdata_d;
    end
  end

  assign interrupt_lines = irq_q;
  assign reg_rdata       = rdata_q;

endmodule

// File: tb/tb_irq_source_conditioner.sv
// Self-checking bench: directed register/latency scenarios plus random
// traffic against a sample-history reference model.
module tb_irq_source_conditioner;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] raw_lines = '0;
  logic        reg_we = 1'b0;
  logic        reg_re = 1'b0;
  logic [1:0]  reg_addr = '0;
  logic [15:0] reg_wdata = '0;
  logic [15:0] reg_rdata;
  logic [15:0] interrupt_lines;

  int n_chk = 0;
  int n_ok  = 0;

  irq_source_conditioner #(
    .SYNC_STAGES (S),
    .RESET_ENABLE(16'h0000)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .raw_lines      (raw_lines),
    .reg_we         (reg_we),
    .reg_re         (reg_re),
    .reg_addr       (reg_addr),
    .reg_wdata      (reg_wdata),
    .reg_rdata      (reg_rdata),
    .interrupt_lines(interrupt_lines)
  );

  always #5 clk = ~clk;

  // Reference: the line the logic sees is the raw value sampled
  // S edges earlier; an event is that value, or its 0->1 step.
  logic [15:0] m_hist[$];
  logic [15:0] m_prev, m_en, m_edge, m_status, m_irq, m_rdata;

  task automatic chk(string tag, logic [15:0] got, logic [15:0] exp);
    n_chk++;
    if (got === exp) n_ok++;
    else $display("FAIL %s: got %h, want %h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_edge();
    logic [15:0] s, ev, c;
    if (reset) begin
      m_hist = {};
      for (int i = 0; i < S; i++) m_hist.push_back(16'h0);
      m_prev = 0; m_en = 16'h0000; m_edge = 0;
      m_status = 0; m_irq = 0; m_rdata = 0;
      return;
    end
    s  = m_hist[S-1];
    ev = 0;
    for (int i = 0; i < 16; i++)
      ev[i] = m_edge[i] ? (s[i] && !m_prev[i]) : s[i];
    if (reg_re) begin
      case (reg_addr)
        2'd0: m_rdata = m_en;
        2'd1: m_rdata = m_edge;
        2'd2: m_rdata = m_status;
        default: m_rdata = s;
      endcase
    end
    c = (reg_we && reg_addr == 2'd2) ? reg_wdata : 16'h0;
    m_irq    = m_en & ev;
    m_status = (m_status & ~c) | ev;
    if (reg_we && reg_addr == 2'd0) m_en = reg_wdata;
    if (reg_we && reg_addr == 2'd1) m_edge = reg_wdata;
    m_prev = s;
    m_hist.push_front(raw_lines);
    void'(m_hist.pop_back());
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    chk("irq", interrupt_lines, m_irq);
    chk("rdata", reg_rdata, m_rdata);
  endtask

  task automatic wr(logic [1:0] a, logic [15:0] d);
    reg_we = 1'b1; reg_addr = a; reg_wdata = d;
    cyc();
    reg_we = 1'b0;
  endtask

  task automatic rd(logic [1:0] a);
    reg_re = 1'b1; reg_addr = a;
    cyc();
    reg_re = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    logic [15:0] g;
    do_reset();
    chk("rst_irq", interrupt_lines, 16'h0000);
    chk("rst_rdata", reg_rdata, 16'h0000);
    rd(2'd0);
    chk("rst_en", reg_rdata, 16'h0000);

    // Edge mode: one pulse two edges after first sample.
    wr(2'd0, 16'h0001);
    wr(2'd1, 16'h0001);
    raw_lines = 16'h0001;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("edge_pulse", interrupt_lines,
          (i == 2) ? 16'h0001 : 16'h0000);
    end
    raw_lines = 16'h0000;
    rd(2'd2);
    chk("edge_status", reg_rdata, 16'h0001);

    // Level mode on line 7.
    do_reset();
    wr(2'd0, 16'h0080);
    raw_lines = 16'h0080;
    for (int i = 0; i < 9; i++) begin
      if (i == 5) raw_lines = 16'h0000;
      cyc();
      chk("level", interrupt_lines,
          (i >= 2 && i < 7) ? 16'h0080 : 16'h0000);
    end

    // Masked edge event still sets sticky status; W1C clears it.
    do_reset();
    wr(2'd1, 16'h8000);
    raw_lines = 16'h8000;
    cyc();
    raw_lines = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("masked", interrupt_lines, 16'h0000);
    end
    rd(2'd2);
    chk("st_8000", reg_rdata, 16'h8000);
    wr(2'd2, 16'h8000);
    rd(2'd2);
    chk("st_clr", reg_rdata, 16'h0000);

    // Clear racing a new event on line 2: the set wins.
    wr(2'd1, 16'h0004);
    raw_lines = 16'h0004;
    cyc();
    cyc();
    wr(2'd2, 16'h0004);
    rd(2'd2);
    chk("set_wins", reg_rdata & 16'h0004, 16'h0004);
    raw_lines = 16'h0000;

    // Reset in the middle of a level request; no output after release.
    do_reset();
    wr(2'd0, 16'h0008);
    raw_lines = 16'h0008;
    repeat (4) cyc();
    chk("lvl3_on", interrupt_lines, 16'h0008);
    reset = 1'b1;
    cyc();
    chk("lvl3_rst", interrupt_lines, 16'h0000);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("post_rst", interrupt_lines, 16'h0000);
    end
    rd(2'd0);
    chk("en_rst", reg_rdata, 16'h0000);

    // SYNC_RAW readback; writes there are ignored.
    raw_lines = 16'hA5A5;
    repeat (3) cyc();
    rd(2'd3);
    chk("sync_raw", reg_rdata, 16'hA5A5);
    wr(2'd3, 16'h1234);
    rd(2'd3);
    chk("sync_ro", reg_rdata, 16'hA5A5);

    // Simultaneous write and read of one register returns old value.
    wr(2'd0, 16'h00F0);
    reg_we = 1'b1; reg_re = 1'b1;
    reg_addr = 2'd0; reg_wdata = 16'h0F0F;
    cyc();
    reg_we = 1'b0; reg_re = 1'b0;
    chk("rw_old", reg_rdata, 16'h00F0);
    rd(2'd0);
    chk("rw_new", reg_rdata, 16'h0F0F);

    // Random traffic, including unsampled glitches and resets.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0)
        raw_lines = 16'($urandom);
      reg_we    = ($urandom_range(0, 3) == 0);
      reg_re    = ($urandom_range(0, 1) == 0);
      reg_addr  = 2'($urandom_range(0, 3));
      reg_wdata = 16'($urandom);
      reset     = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 7) == 0) begin
        g = 16'($urandom);
        #2 raw_lines = raw_lines ^ g;
        #2 raw_lines = raw_lines ^ g;
      end
      cyc();
    end
    reset = 1'b0; reg_we = 1'b0; reg_re = 1'b0;

    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

endmodule
